// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: shares the sprite attribute RAM read port between scan and host byte reads
module sprite_ram_arbiter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        host_wr_i,
  input  logic        host_rd_i,
  input  logic [9:0]  host_addr_i,
  input  logic [7:0]  host_wr_data_i,
  output logic [7:0]  host_rd_data_o,
  output logic        host_rd_valid_o,
  output logic        host_busy_o,
  input  logic        scan_start_i,
  input  logic [6:0]  scan_first_i,
  input  logic [7:0]  scan_count_i,
  output logic [31:0] scan_data_o,
  output logic        scan_valid_o,
  output logic [6:0]  scan_sprite_o,
  output logic        scan_half_o,
  output logic        scan_done_o,
  output logic        scan_busy_o,
  output logic        ram_wr_en_o,
  output logic [3:0]  ram_ben_o,
  output logic [7:0]  ram_wr_addr_o,
  output logic [31:0] ram_wr_data_o,
  output logic [7:0]  ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [6:0] sprite, tag_sprite;
  logic half, tag_half;
  logic [8:0] remaining;
  logic pending, last_scan, host_inflight, scan_inflight;
  logic [9:0] rd_addr;
  logic [7:0] last_rd_addr;
  logic host_elig, scan_elig, host_gnt, scan_gnt;
  // a host read of the word being written this cycle waits so it sees the new data
  always_comb begin
    host_elig = pending && !(ram_wr_en_o && ram_wr_addr_o == rd_addr[9:2]);
    scan_elig = state == RUN;
    host_gnt = host_elig && (!scan_elig || last_scan);
    scan_gnt = scan_elig && !host_gnt;
    ram_rd_addr_o = host_gnt ? rd_addr[9:2] : scan_gnt ? {sprite, half} : last_rd_addr;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ram_wr_en_o <= 1'b0;
      ram_ben_o <= 4'b0000;
      ram_wr_addr_o <= 8'd0;
      ram_wr_data_o <= 32'd0;
    end else begin
      ram_wr_en_o <= host_wr_i;
      ram_ben_o <= host_wr_i ? 4'b0001 << host_addr_i[1:0] : 4'b0000;
      if (host_wr_i) begin
        ram_wr_addr_o <= host_addr_i[9:2];
        ram_wr_data_o <= {4{host_wr_data_i}};
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending <= 1'b0;
      host_busy_o <= 1'b0;
      rd_addr <= 10'd0;
      host_inflight <= 1'b0;
      host_rd_valid_o <= 1'b0;
      host_rd_data_o <= 8'd0;
      last_scan <= 1'b0;
      last_rd_addr <= 8'd0;
    end else begin
      if (host_rd_i && !host_busy_o) begin
        pending <= 1'b1;
        host_busy_o <= 1'b1;
        rd_addr <= host_addr_i;
      end else begin
        if (host_gnt) pending <= 1'b0;
        if (host_inflight) host_busy_o <= 1'b0;
      end
      host_inflight <= host_gnt;
      host_rd_valid_o <= host_inflight;
      if (host_inflight) host_rd_data_o <= ram_rd_data_i[8*rd_addr[1:0] +: 8];
      if (host_gnt || scan_gnt) begin
        last_scan <= scan_gnt;
        last_rd_addr <= ram_rd_addr_o;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      scan_busy_o <= 1'b0;
      sprite <= 7'd0;
      half <= 1'b0;
      remaining <= 9'd0;
      scan_inflight <= 1'b0;
      tag_sprite <= 7'd0;
      tag_half <= 1'b0;
      scan_valid_o <= 1'b0;
      scan_data_o <= 32'd0;
      scan_sprite_o <= 7'd0;
      scan_half_o <= 1'b0;
      scan_done_o <= 1'b0;
    end else begin
      scan_inflight <= scan_gnt;
      scan_valid_o <= scan_inflight;
      scan_done_o <= 1'b0;
      if (scan_gnt) begin
        tag_sprite <= sprite;
        tag_half <= half;
      end
      if (scan_inflight) begin
        scan_data_o <= ram_rd_data_i;
        scan_sprite_o <= tag_sprite;
        scan_half_o <= tag_half;
      end
      case (state)
        IDLE: if (scan_start_i) begin
          sprite <= scan_first_i;
          half <= 1'b0;
          remaining <= scan_count_i == 8'd0 ? 9'd256 : {scan_count_i, 1'b0};
          state <= RUN;
          scan_busy_o <= 1'b1;
        end
        RUN: if (scan_gnt) begin
          half <= ~half;
          if (half) sprite <= sprite + 7'd1;
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) state <= DRAIN;
        end
        // last word is out once valid shows with nothing left in flight
        DRAIN: if (scan_valid_o && !scan_inflight) begin
          scan_done_o <= 1'b1;
          state <= IDLE;
          scan_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// tb_sprite_ram_arbiter: randomized bench with a read-first RAM model and a byte-level reference image
`timescale 1ns/1ps
module tb_sprite_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic host_wr, host_rd, scan_start;
  logic [9:0] host_addr;
  logic [7:0] host_wr_data, host_rd_data, scan_count;
  logic host_rd_valid, host_busy, scan_valid, scan_half, scan_done, scan_busy;
  logic [6:0] scan_first, scan_sprite;
  logic [31:0] scan_data, ram_wr_data, ram_rd_data;
  logic ram_wr_en;
  logic [3:0] ram_ben;
  logic [7:0] ram_wr_addr, ram_rd_addr;
  int compared = 0, mismatched = 0, cyc = 0;
  logic [7:0] ref_mem [1024];
  logic [31:0] mem [256];
  logic [31:0] wmask;
  logic init = 1'b1;
  typedef struct { logic [6:0] sprite; logic half; logic [31:0] data; int at; } scan_t;
  scan_t scan_q[$], exp_q[$];
  logic [7:0] host_q[$];
  int host_at[$], done_at[$];

  always #5 clk = ~clk;

  sprite_ram_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .host_wr_i(host_wr), .host_rd_i(host_rd), .host_addr_i(host_addr), .host_wr_data_i(host_wr_data),
    .host_rd_data_o(host_rd_data), .host_rd_valid_o(host_rd_valid), .host_busy_o(host_busy),
    .scan_start_i(scan_start), .scan_first_i(scan_first), .scan_count_i(scan_count),
    .scan_data_o(scan_data), .scan_valid_o(scan_valid), .scan_sprite_o(scan_sprite),
    .scan_half_o(scan_half), .scan_done_o(scan_done), .scan_busy_o(scan_busy),
    .ram_wr_en_o(ram_wr_en), .ram_ben_o(ram_ben), .ram_wr_addr_o(ram_wr_addr),
    .ram_wr_data_o(ram_wr_data), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data)
  );

  function automatic logic [31:0] ref_word(int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // RAM: synchronous read returning pre-write contents, byte-enabled write
  always_comb wmask = {{8{ram_ben[3]}}, {8{ram_ben[2]}}, {8{ram_ben[1]}}, {8{ram_ben[0]}}};
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_word(i);
    end else begin
      ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= (mem[ram_wr_addr] & ~wmask) | (ram_wr_data & wmask);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_valid) scan_q.push_back(scan_t'{scan_sprite, scan_half, scan_data, cyc});
    if (host_rd_valid) begin
      host_q.push_back(host_rd_data);
      host_at.push_back(cyc);
    end
    if (scan_done) done_at.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    host_wr = 1'b1; host_addr = a; host_wr_data = d; ref_mem[a] = d;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [9:0] a, output logic [7:0] d, output int lat, output bit ok, output logic busy1);
    int n0, t0, n;
    n0 = host_q.size(); host_rd = 1'b1; host_addr = a; t0 = cyc;
    tick();
    host_rd = 1'b0;
    @(negedge clk);
    busy1 = host_busy;
    n = 0;
    while (host_q.size() <= n0 && n < 16) begin @(posedge clk); n++; end
    #1;
    ok = host_q.size() > n0;
    d = ok ? host_q[n0] : 8'hxx;
    lat = ok ? host_at[n0] - t0 : -1;
  endtask

  task automatic start_scan(input logic [6:0] f, input logic [7:0] c, output int s0);
    scan_q.delete(); done_at.delete();
    scan_start = 1'b1; scan_first = f; scan_count = c; s0 = cyc;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done_at.size() == 0 && n < budget) begin @(posedge clk); n++; end
    #1;
    ok = done_at.size() > 0;
  endtask

  // Reference scan order: word i belongs to sprite (first + i/2) mod 128, half i mod 2
  task automatic model_scan(input logic [6:0] f, input logic [7:0] c);
    int n, sp;
    exp_q.delete();
    n = (c == 8'd0) ? 256 : 2 * int'(c);
    for (int i = 0; i < n; i++) begin
      sp = (int'(f) + i / 2) % 128;
      exp_q.push_back(scan_t'{7'(sp), 1'(i % 2), ref_word(sp * 2 + i % 2), 0});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    compared++;
    if ({host_rd_data, host_rd_valid, host_busy} !== 10'd0) begin
      mismatched++; $display("FAIL reset_host: got data=%h valid=%b busy=%b want all 0", host_rd_data, host_rd_valid, host_busy);
    end
    compared++;
    if ({scan_data, scan_valid, scan_sprite, scan_half, scan_done, scan_busy} !== 43'd0) begin
      mismatched++; $display("FAIL reset_scan: got data=%h valid=%b sprite=%0d busy=%b want all 0", scan_data, scan_valid, scan_sprite, scan_busy);
    end
    compared++;
    if ({ram_wr_en, ram_ben, ram_wr_addr, ram_wr_data, ram_rd_addr} !== 53'd0) begin
      mismatched++; $display("FAIL reset_ram: got en=%b ben=%b waddr=%h wdata=%h raddr=%h want all 0", ram_wr_en, ram_ben, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] d, dw;
    logic [9:0] a, r;
    int lat;
    bit ok;
    logic b1;
    host_wr = 1'b1; host_addr = 10'h006; host_wr_data = 8'hA5; ref_mem[10'h006] = 8'hA5;
    tick();
    host_wr = 1'b0;
    @(negedge clk);
    compared++;
    if ({ram_wr_en, ram_wr_addr, ram_ben, ram_wr_data} !== {1'b1, 8'h01, 4'b0100, 32'hA5A5A5A5}) begin
      mismatched++; $display("FAIL write_a5: got en=%b addr=%h ben=%b data=%h want en=1 addr=01 ben=0100 data=a5a5a5a5", ram_wr_en, ram_wr_addr, ram_ben, ram_wr_data);
    end
    tick();
    host_read(10'h006, d, lat, ok, b1);
    compared++;
    if (!ok || d !== 8'hA5 || lat != 3) begin
      mismatched++; $display("FAIL read_a5: got ok=%b data=%h lat=%0d want data=a5 lat=3", ok, d, lat);
    end
    compared++;
    if (b1 !== 1'b1) begin
      mismatched++; $display("FAIL read_busy: got busy=%b at T+1 want 1", b1);
    end
    for (int i = 0; i < 8; i++) begin
      a = 10'($urandom_range(0, 1023)); dw = 8'($urandom);
      do_write(a, dw);
      compared++;
      @(negedge clk);
      if ({ram_wr_en, ram_wr_addr, ram_ben, ram_wr_data} !== {1'b1, a[9:2], 4'b0001 << a[1:0], {4{dw}}}) begin
        mismatched++; $display("FAIL rand_write%0d: got en=%b addr=%h ben=%b data=%h want addr=%h byte=%0d data=%h", i, ram_wr_en, ram_wr_addr, ram_ben, ram_wr_data, a[9:2], a[1:0], dw);
      end
      tick();
      r = (i % 2 == 0) ? a : 10'($urandom_range(0, 1023));
      host_read(r, d, lat, ok, b1);
      compared++;
      if (!ok || d !== ref_mem[r] || lat != 3) begin
        mismatched++; $display("FAIL rand_read%0d: addr=%h got ok=%b data=%h lat=%0d want data=%h lat=3", i, r, ok, d, lat, ref_mem[r]);
      end
    end
  endtask

  task automatic test_scan_wrap();
    int s0;
    bit ok, contig;
    model_scan(7'd126, 8'd3);
    start_scan(7'd126, 8'd3, s0);
    wait_done(40, ok);
    compared++;
    if (!ok || scan_q.size() != 6) begin
      mismatched++; $display("FAIL wrap_count: got done=%b words=%0d want done=1 words=6", ok, scan_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= scan_q.size() || {scan_q[i].sprite, scan_q[i].half, scan_q[i].data} !== {exp_q[i].sprite, exp_q[i].half, exp_q[i].data}) begin
        mismatched++; $display("FAIL wrap_word%0d: got sprite=%0d half=%b data=%h want sprite=%0d half=%b data=%h", i, scan_q[i].sprite, scan_q[i].half, scan_q[i].data, exp_q[i].sprite, exp_q[i].half, exp_q[i].data);
      end
    end
    contig = scan_q.size() == 6 && scan_q[0].at == s0 + 3;
    for (int i = 1; i < scan_q.size(); i++) if (scan_q[i].at != scan_q[i-1].at + 1) contig = 1'b0;
    compared++;
    if (!contig) begin
      mismatched++; $display("FAIL wrap_timing: got first valid at +%0d or gaps, want +3 and 6 consecutive", scan_q.size() > 0 ? scan_q[0].at - s0 : -1);
    end
    compared++;
    if (done_at.size() != 1 || scan_q.size() == 0 || done_at[0] != scan_q[$].at + 1 || scan_busy !== 1'b0) begin
      mismatched++; $display("FAIL wrap_done: got pulses=%0d busy=%b want one pulse right after last valid, busy 0", done_at.size(), scan_busy);
    end
  endtask

  task automatic test_contention();
    int s0, lat;
    bit ok;
    logic [6:0] f;
    logic [9:0] a;
    logic [7:0] d;
    logic b1;
    f = 7'($urandom);
    model_scan(f, 8'd4);
    start_scan(f, 8'd4, s0);
    for (int k = 0; k < 4; k++) begin
      a = 10'($urandom_range(0, 1023));
      host_read(a, d, lat, ok, b1);
      compared++;
      if (!ok || d !== ref_mem[a] || lat < 3 || lat > 5) begin
        mismatched++; $display("FAIL cont_read%0d: addr=%h got ok=%b data=%h lat=%0d want data=%h lat 3..5", k, a, ok, d, lat, ref_mem[a]);
      end
    end
    wait_done(60, ok);
    compared++;
    if (!ok || scan_q.size() != 8 || done_at[0] - s0 > 22) begin
      mismatched++; $display("FAIL cont_scan: got done=%b words=%0d want done=1 words=8 within 22 cycles", ok, scan_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= scan_q.size() || {scan_q[i].sprite, scan_q[i].half, scan_q[i].data} !== {exp_q[i].sprite, exp_q[i].half, exp_q[i].data}) begin
        mismatched++; $display("FAIL cont_word%0d: got sprite=%0d half=%b data=%h want sprite=%0d half=%b data=%h", i, scan_q[i].sprite, scan_q[i].half, scan_q[i].data, exp_q[i].sprite, exp_q[i].half, exp_q[i].data);
      end
    end
  endtask

  task automatic test_hazard();
    logic [1:0] b;
    logic [9:0] a;
    logic [7:0] d;
    int n0, t0, n, lat;
    bit ok;
    logic b1;
    b = 2'($urandom);
    a = {8'h10, b};
    d = ~ref_mem[a];
    host_wr = 1'b1; host_rd = 1'b1; host_addr = a; host_wr_data = d; ref_mem[a] = d;
    n0 = host_q.size(); t0 = cyc;
    tick();
    host_wr = 1'b0; host_rd = 1'b0;
    n = 0;
    while (host_q.size() <= n0 && n < 16) begin @(posedge clk); n++; end
    #1;
    ok = host_q.size() > n0;
    compared++;
    if (!ok || host_q[n0] !== d || host_at[n0] - t0 != 4) begin
      mismatched++; $display("FAIL hazard: got ok=%b data=%h lat=%0d want data=%h lat=4", ok, host_q[n0], host_at[n0] - t0, d);
    end
    a = {8'h10, b ^ 2'd1};
    host_read(a, d, lat, ok, b1);
    compared++;
    if (!ok || d !== ref_mem[a] || lat != 3) begin
      mismatched++; $display("FAIL hazard_neighbour: got data=%h lat=%0d want data=%h lat=3", d, lat, ref_mem[a]);
    end
  endtask

  task automatic test_count_zero();
    int s0;
    bit ok, contig;
    logic [6:0] f;
    f = 7'($urandom);
    model_scan(f, 8'd0);
    start_scan(f, 8'd0, s0);
    repeat (4) tick();
    scan_start = 1'b1; scan_first = f + 7'd40; scan_count = 8'd1;
    tick();
    scan_start = 1'b0;
    wait_done(600, ok);
    compared++;
    if (!ok || scan_q.size() != 256) begin
      mismatched++; $display("FAIL zero_count: got done=%b words=%0d want done=1 words=256", ok, scan_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= scan_q.size() || {scan_q[i].sprite, scan_q[i].half, scan_q[i].data} !== {exp_q[i].sprite, exp_q[i].half, exp_q[i].data}) begin
        mismatched++; $display("FAIL zero_word%0d: got sprite=%0d half=%b data=%h want sprite=%0d half=%b data=%h", i, scan_q[i].sprite, scan_q[i].half, scan_q[i].data, exp_q[i].sprite, exp_q[i].half, exp_q[i].data);
      end
    end
    contig = scan_q.size() == 256 && scan_q[0].at == s0 + 3;
    for (int i = 1; i < scan_q.size(); i++) if (scan_q[i].at != scan_q[i-1].at + 1) contig = 1'b0;
    compared++;
    if (!contig) begin
      mismatched++; $display("FAIL zero_timing: got %0d words, not 256 consecutive starting at +3", scan_q.size());
    end
    repeat (10) tick();
    compared++;
    if (scan_q.size() != 256 || done_at.size() != 1 || scan_busy !== 1'b0) begin
      mismatched++; $display("FAIL zero_restart: got words=%0d done pulses=%0d busy=%b want 256/1/0", scan_q.size(), done_at.size(), scan_busy);
    end
  endtask

  task automatic test_reset_mid();
    int s0, n0;
    bit ok, contig;
    logic [6:0] f;
    f = 7'($urandom);
    start_scan(f, 8'd8, s0);
    repeat (3) tick();
    host_rd = 1'b1; host_addr = 10'($urandom_range(0, 1023)); n0 = host_q.size();
    tick();
    host_rd = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({host_rd_data, host_rd_valid, host_busy} !== 10'd0) begin
      mismatched++; $display("FAIL midrst_host: got data=%h valid=%b busy=%b want all 0", host_rd_data, host_rd_valid, host_busy);
    end
    compared++;
    if ({scan_data, scan_valid, scan_sprite, scan_half, scan_done, scan_busy} !== 43'd0) begin
      mismatched++; $display("FAIL midrst_scan: got data=%h valid=%b sprite=%0d busy=%b want all 0", scan_data, scan_valid, scan_sprite, scan_busy);
    end
    compared++;
    if ({ram_wr_en, ram_ben, ram_wr_addr, ram_wr_data, ram_rd_addr} !== 53'd0) begin
      mismatched++; $display("FAIL midrst_ram: got en=%b waddr=%h wdata=%h raddr=%h want all 0", ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    tick();
    repeat (5) tick();
    compared++;
    if (host_q.size() != n0 || scan_busy !== 1'b0) begin
      mismatched++; $display("FAIL midrst_stale: got %0d late host returns busy=%b want 0 and 0", host_q.size() - n0, scan_busy);
    end
    f = 7'($urandom);
    model_scan(f, 8'd2);
    start_scan(f, 8'd2, s0);
    wait_done(40, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= scan_q.size() || {scan_q[i].sprite, scan_q[i].half, scan_q[i].data} !== {exp_q[i].sprite, exp_q[i].half, exp_q[i].data}) begin
        mismatched++; $display("FAIL midrst_word%0d: got sprite=%0d half=%b data=%h want sprite=%0d half=%b data=%h", i, scan_q[i].sprite, scan_q[i].half, scan_q[i].data, exp_q[i].sprite, exp_q[i].half, exp_q[i].data);
      end
    end
    contig = ok && scan_q.size() == 4 && scan_q[0].at == s0 + 3 && done_at[0] == s0 + 7;
    for (int i = 1; i < scan_q.size(); i++) if (scan_q[i].at != scan_q[i-1].at + 1) contig = 1'b0;
    compared++;
    if (!contig) begin
      mismatched++; $display("FAIL midrst_rescan: got done=%b words=%0d want 4 consecutive words from +3 and done at +7", ok, scan_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host_wr = 1'b0; host_rd = 1'b0; scan_start = 1'b0;
    host_addr = 10'd0; host_wr_data = 8'd0; scan_first = 7'd0; scan_count = 8'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    tick();
    init = 1'b0;
    test_reset();
    test_write_read();
    test_scan_wrap();
    test_contention();
    test_hazard();
    test_count_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
